// File: rtl/axi4_lite_slave_regfile.sv
// rtl/axi4_lite_slave_regfile.sv - AXI4-Lite slave exposing a bank of memory-mapped registers
//
// Purpose:
//   A parametrised AXI4-Lite slave with NUM_REGS registers of DATA_WIDTH bits each.
//   Write and read channels have their own FSMs and never stall each other.
//   AW and W may arrive in either order; byte strobes are honoured; out-of-range
//   accesses and writes to read-only registers return SLVERR. Register contents are
//   exported flat on regs_out.
//
// Ports:
//   ACLK, ARESET                : clock (rising edge) and synchronous active-high reset
//   AWADDR/AWPROT/AWVALID/AWREADY : write address channel (AWPROT ignored)
//   WDATA/WSTRB/WVALID/WREADY   : write data channel
//   BRESP/BVALID/BREADY         : write response channel
//   ARADDR/ARPROT/ARVALID/ARREADY : read address channel (ARPROT ignored)
//   RDATA/RRESP/RVALID/RREADY   : read data channel
//   regs_out                    : register i at bits [i*DATA_WIDTH +: DATA_WIDTH]

module axi4_lite_slave_regfile #(
    parameter int                       ADDR_WIDTH  = 32,
    parameter int                       DATA_WIDTH  = 32,
    parameter int                       NUM_REGS    = 16,
    parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR   = '0,
    parameter logic [NUM_REGS-1:0]      RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0]    RESET_VALUE = '0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,

    input  logic [ADDR_WIDTH-1:0]           AWADDR,
    input  logic [2:0]                      AWPROT,
    input  logic                            AWVALID,
    output logic                            AWREADY,

    input  logic [DATA_WIDTH-1:0]           WDATA,
    input  logic [DATA_WIDTH/8-1:0]         WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,

    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,

    input  logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic [2:0]                      ARPROT,
    input  logic                            ARVALID,
    output logic                            ARREADY,

    output logic [DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,

    output logic [NUM_REGS*DATA_WIDTH-1:0]  regs_out
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    // Bank size in bytes, one bit wider than the address so the borrow of the
    // offset subtraction can be folded into a single range compare.
    localparam logic [ADDR_WIDTH:0] BANK_BYTES = (ADDR_WIDTH+1)'(NUM_REGS * STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Address decode helpers
    // ------------------------------------------------------------------

    // An address below BASE_ADDR borrows into the top bit of the offset, which
    // makes the offset larger than any legal bank size, so one compare covers
    // both ends of the window.
    function automatic logic [ADDR_WIDTH:0] addr_offset(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} - {1'b0, BASE_ADDR};
    endfunction

    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return addr_offset(a) < BANK_BYTES;
    endfunction

    // Low LSB bits are dropped, so misaligned addresses hit the containing word.
    function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(addr_offset(a) >> LSB);
    endfunction

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_regs_out
            assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT_DATA,
        W_WAIT_ADDR,
        W_RESP
    } wstate_t;

    wstate_t                w_state;
    wstate_t                w_next;

    logic [ADDR_WIDTH-1:0]  aw_addr_q;
    logic [DATA_WIDTH-1:0]  w_data_q;
    logic [STRB_W-1:0]      w_strb_q;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   cap_addr;
    logic                   cap_data;
    logic                   commit;
    logic [ADDR_WIDTH-1:0]  cmt_addr;
    logic [DATA_WIDTH-1:0]  cmt_data;
    logic [STRB_W-1:0]      cmt_strb;
    logic [IDX_W-1:0]       cmt_idx;
    logic                   cmt_ok;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Next state plus the commit mux: whichever half of the write arrived
    // earlier comes from its capture register, the other half from the bus.
    always_comb begin
        w_next   = w_state;
        cap_addr = 1'b0;
        cap_data = 1'b0;
        commit   = 1'b0;
        cmt_addr = AWADDR;
        cmt_data = WDATA;
        cmt_strb = WSTRB;

        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    cap_addr = 1'b1;
                    w_next   = W_WAIT_DATA;
                end else if (w_hs) begin
                    cap_data = 1'b1;
                    w_next   = W_WAIT_ADDR;
                end
            end
            W_WAIT_DATA: begin
                cmt_addr = aw_addr_q;
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_WAIT_ADDR: begin
                cmt_data = w_data_q;
                cmt_strb = w_strb_q;
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_next = W_IDLE;
                end
            end
            default: begin
                w_next = W_IDLE;
            end
        endcase
    end

    assign cmt_idx = addr_index(cmt_addr);
    assign cmt_ok  = addr_in_range(cmt_addr) && !RO_MASK[cmt_idx];

    // Ready/valid outputs are registered copies of what the next state implies,
    // so they are correct in the very cycle the FSM enters a state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state   <= W_IDLE;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            BRESP     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else begin
            w_state <= w_next;
            AWREADY <= (w_next == W_IDLE) || (w_next == W_WAIT_ADDR);
            WREADY  <= (w_next == W_IDLE) || (w_next == W_WAIT_DATA);
            BVALID  <= (w_next == W_RESP);

            if (cap_addr) begin
                aw_addr_q <= AWADDR;
            end
            if (cap_data) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end

            if (commit) begin
                BRESP <= cmt_ok ? RESP_OKAY : RESP_SLVERR;
                if (cmt_ok) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (cmt_strb[k]) begin
                            regs[cmt_idx][8*k +: 8] <= cmt_data[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rstate_t;

    rstate_t            r_state;
    rstate_t            r_next;

    logic               ar_hs;
    logic [IDX_W-1:0]   rd_idx;
    logic               rd_ok;

    assign ar_hs  = ARVALID && ARREADY;
    assign rd_idx = addr_index(ARADDR);
    assign rd_ok  = addr_in_range(ARADDR);

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_next = R_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    r_next = R_IDLE;
                end
            end
            default: begin
                r_next = R_IDLE;
            end
        endcase
    end

    // RDATA samples the storage before any same-edge write commit lands, so a
    // colliding read returns the old value.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RDATA   <= '0;
            RRESP   <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            ARREADY <= (r_next == R_IDLE);
            RVALID  <= (r_next == R_RESP);
            if (ar_hs) begin
                RDATA <= rd_ok ? regs[rd_idx] : '0;
                RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Protection bits carry no meaning for this register bank.
    logic unused_prot;
    assign unused_prot = ^{AWPROT, ARPROT};

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb/tb_axi4_lite_slave_regfile.sv - directed self-checking bench for axi4_lite_slave_regfile

module tb_axi4_lite_slave_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic areset;

    // 32-bit instance, 16 registers, register 3 read-only
    logic [31:0]     awaddr, wdata, araddr, rdata;
    logic [2:0]      awprot, arprot;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rvalid, rready;
    logic [16*32-1:0] regs_out;

    // 64-bit instance, 8 registers
    logic [31:0]     b_awaddr, b_araddr;
    logic [63:0]     b_wdata, b_rdata;
    logic [7:0]      b_wstrb;
    logic [1:0]      b_bresp, b_rresp;
    logic            b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
    logic            b_arvalid, b_arready, b_rvalid, b_rready;
    logic [8*64-1:0] b_regs_out;

    axi4_lite_slave_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16),
        .BASE_ADDR(32'h0), .RO_MASK(16'h0008), .RESET_VALUE(32'h0)
    ) dut_a (
        .ACLK(clk), .ARESET(areset),
        .AWADDR(awaddr), .AWPROT(awprot), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARPROT(arprot), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .regs_out(regs_out)
    );

    axi4_lite_slave_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_REGS(8),
        .BASE_ADDR(32'h0), .RO_MASK(8'h00), .RESET_VALUE(64'h0)
    ) dut_b (
        .ACLK(clk), .ARESET(areset),
        .AWADDR(b_awaddr), .AWPROT(3'b000), .AWVALID(b_awvalid), .AWREADY(b_awready),
        .WDATA(b_wdata), .WSTRB(b_wstrb), .WVALID(b_wvalid), .WREADY(b_wready),
        .BRESP(b_bresp), .BVALID(b_bvalid), .BREADY(b_bready),
        .ARADDR(b_araddr), .ARPROT(3'b000), .ARVALID(b_arvalid), .ARREADY(b_arready),
        .RDATA(b_rdata), .RRESP(b_rresp), .RVALID(b_rvalid), .RREADY(b_rready),
        .regs_out(b_regs_out)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] reg_a(input int i);
        return regs_out[i*32 +: 32];
    endfunction

    function automatic logic [63:0] reg_b(input int i);
        return b_regs_out[i*64 +: 64];
    endfunction

    // AW and W presented together; each valid drops after its own handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        bit aw_done, w_done, aw_f, w_f;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            tick();
            if (aw_f) begin awvalid = 1'b0; aw_done = 1; end
            if (w_f)  begin wvalid  = 1'b0; w_done  = 1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_handshake", 64'(aw_done && w_done), 64'd1);
        chk("bvalid_latency", 64'(bvalid), 64'd1);
        resp = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_clear", 64'(bvalid), 64'd0);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit done, f;
        int n;
        done = 0; n = 0;
        araddr = a; arvalid = 1'b1;
        while (!done && n < 20) begin
            f = arvalid && arready;
            tick();
            if (f) begin arvalid = 1'b0; done = 1; end
            n++;
        end
        arvalid = 1'b0;
        chk("rd_handshake", 64'(done), 64'd1);
        chk("rvalid_latency", 64'(rvalid), 64'd1);
        d = rdata;
        resp = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        chk("rvalid_clear", 64'(rvalid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  r;
        logic [31:0] d;

        vecs[0]  = '{1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h08, 32'h11223344, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h40, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[5]  = '{1'b1, 32'h0C, 32'h00000005, 4'hF, 2'b10, 32'h0};
        vecs[6]  = '{1'b0, 32'h0C, 32'h0,        4'h0, 2'b00, 32'h0};
        vecs[7]  = '{1'b1, 32'h3C, 32'hCAFEF00D, 4'hC, 2'b00, 32'h0};
        vecs[8]  = '{1'b0, 32'h3E, 32'h0,        4'h0, 2'b00, 32'hCAFE0000};
        vecs[9]  = '{1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        vecs[10] = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'h0};

        areset = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
        awprot = 3'b000; arprot = 3'b000;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        b_awaddr = '0; b_araddr = '0; b_wdata = '0; b_wstrb = '0;
        b_awvalid = 0; b_wvalid = 0; b_bready = 0; b_arvalid = 0; b_rready = 0;

        // Reset state
        tick();
        tick();
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready",  64'(wready),  64'd0);
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_bvalid",  64'(bvalid),  64'd0);
        chk("rst_rvalid",  64'(rvalid),  64'd0);
        chk("rst_bresp",   64'(bresp),   64'd0);
        chk("rst_rdata",   64'(rdata),   64'd0);
        areset = 1'b0;
        tick();
        chk("post_rst_awready", 64'(awready), 64'd1);
        chk("post_rst_wready",  64'(wready),  64'd1);
        chk("post_rst_arready", 64'(arready), 64'd1);
        chk("post_rst_b_awready", 64'(b_awready), 64'd1);

        // Table-driven single transactions
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                chk($sformatf("v%0d_bresp", i), 64'(r), 64'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, d, r);
                chk($sformatf("v%0d_rresp", i), 64'(r), 64'(vecs[i].exp_resp));
                chk($sformatf("v%0d_rdata", i), 64'(d), 64'(vecs[i].exp_rdata));
            end
        end
        chk("regs1",  64'(reg_a(1)),  64'hDEADBEEF);
        chk("regs2",  64'(reg_a(2)),  64'h11223344);
        chk("regs3_ro", 64'(reg_a(3)), 64'h0);
        chk("regs4_nostrb", 64'(reg_a(4)), 64'h0);
        chk("regs15", 64'(reg_a(15)), 64'hCAFE0000);

        // W three cycles ahead of AW
        wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("wfirst_wready", 64'(wready), 64'd0);
            chk("wfirst_awready", 64'(awready), 64'd1);
            chk("wfirst_bvalid", 64'(bvalid), 64'd0);
            tick();
        end
        chk("wfirst_nocommit", 64'(reg_a(2)), 64'h11223344);
        awaddr = 32'h08; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        chk("wfirst_bvalid_set", 64'(bvalid), 64'd1);
        chk("wfirst_bresp", 64'(bresp), 64'd0);
        chk("wfirst_reg2", 64'(reg_a(2)), 64'h11BB33DD);
        bready = 1'b1;
        tick();
        bready = 1'b0;

        // Response back-pressure on both channels
        awaddr = 32'h14; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_bvalid",  64'(bvalid),  64'd1);
            chk("bp_bresp",   64'(bresp),   64'd0);
            chk("bp_rvalid",  64'(rvalid),  64'd1);
            chk("bp_rdata",   64'(rdata),   64'hDEADBEEF);
            chk("bp_awready", 64'(awready), 64'd0);
            chk("bp_arready", 64'(arready), 64'd0);
            tick();
        end
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        chk("bp_release_bvalid",  64'(bvalid),  64'd0);
        chk("bp_release_rvalid",  64'(rvalid),  64'd0);
        chk("bp_release_awready", 64'(awready), 64'd1);
        chk("bp_release_arready", 64'(arready), 64'd1);
        chk("bp_reg5", 64'(reg_a(5)), 64'h55);

        // Reset while write waits for data and read holds a response
        awaddr = 32'h18; awvalid = 1'b1;
        araddr = 32'h08; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        chk("mid_awready", 64'(awready), 64'd0);
        chk("mid_wready",  64'(wready),  64'd1);
        chk("mid_rvalid",  64'(rvalid),  64'd1);
        areset = 1'b1;
        tick();
        chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
        chk("mid_rst_rvalid", 64'(rvalid), 64'd0);
        chk("mid_rst_rdata",  64'(rdata),  64'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("mid_rst_reg%0d", i), 64'(reg_a(i)), 64'h0);
        end
        areset = 1'b0;
        tick();
        chk("after_rst_awready", 64'(awready), 64'd1);
        chk("after_rst_wready",  64'(wready),  64'd1);
        chk("after_rst_arready", 64'(arready), 64'd1);
        chk("after_rst_bvalid",  64'(bvalid),  64'd0);
        chk("after_rst_rvalid",  64'(rvalid),  64'd0);

        // Same-edge write and read of register 1
        awaddr = 32'h04; wdata = 32'h7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h04; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("coll_rvalid", 64'(rvalid), 64'd1);
        chk("coll_rdata_old", 64'(rdata), 64'h0);
        chk("coll_bresp", 64'(bresp), 64'd0);
        chk("coll_reg1", 64'(reg_a(1)), 64'h7);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        do_read(32'h04, d, r);
        chk("coll_rdata_new", 64'(d), 64'h7);

        // 64-bit instance: stride 8, 8-bit strobes
        b_awaddr = 32'h08; b_wdata = 64'h0123456789ABCDEF; b_wstrb = 8'hFF;
        b_awvalid = 1'b1; b_wvalid = 1'b1;
        tick();
        b_awvalid = 1'b0; b_wvalid = 1'b0;
        chk("b_bvalid", 64'(b_bvalid), 64'd1);
        chk("b_bresp", 64'(b_bresp), 64'd0);
        chk("b_reg1", reg_b(1), 64'h0123456789ABCDEF);
        b_bready = 1'b1;
        tick();
        b_bready = 1'b0;
        b_awaddr = 32'h10; b_wdata = 64'hFFFFFFFFFFFFFFFF; b_wstrb = 8'h0F;
        b_awvalid = 1'b1; b_wvalid = 1'b1;
        tick();
        b_awvalid = 1'b0; b_wvalid = 1'b0;
        chk("b_strb_reg2", reg_b(2), 64'h00000000FFFFFFFF);
        b_bready = 1'b1;
        tick();
        b_bready = 1'b0;
        b_araddr = 32'h08; b_arvalid = 1'b1;
        tick();
        b_arvalid = 1'b0;
        chk("b_rvalid", 64'(b_rvalid), 64'd1);
        chk("b_rdata", b_rdata, 64'h0123456789ABCDEF);
        chk("b_rresp", 64'(b_rresp), 64'd0);
        b_rready = 1'b1;
        tick();
        b_rready = 1'b0;
        b_araddr = 32'h40; b_arvalid = 1'b1;
        tick();
        b_arvalid = 1'b0;
        chk("b_oor_rresp", 64'(b_rresp), 64'd2);
        chk("b_oor_rdata", b_rdata, 64'h0);
        b_rready = 1'b1;
        tick();
        b_rready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regfile.md
Name: axi4_lite_slave_regfile

Overview:
Parametrised AXI4-Lite slave exposing a bank of NUM_REGS memory-mapped registers. It generalises the team's IDLE/ADDR/DATA/RESP bus flow: write and read channels run independently, AW and W may arrive in either order, byte strobes are honoured, and decode and read-only errors are reported. Register contents are exported flat to user logic.

Parameters:
ADDR_WIDTH, 32, AXI address width.
DATA_WIDTH, 32, bus and register width; legal values are 32 or 64.
NUM_REGS, 16, number of registers; must be at least 1.
BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to the bank size.
RO_MASK, {NUM_REGS{1'b0}}, bit i set means register i is read-only.
RESET_VALUE, {DATA_WIDTH{1'b0}}, reset value of every register.

Ports:
ACLK  in  1  clock; all logic on the rising edge.
ARESET  in  1  synchronous active-high reset.
AWADDR  in  ADDR_WIDTH  write address.
AWPROT  in  3  accepted and ignored.
AWVALID / AWREADY  in / out  1  write-address handshake.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte enables.
WVALID / WREADY  in / out  1  write-data handshake.
BRESP  out  2  write response.
BVALID / BREADY  out / in  1  write-response handshake.
ARADDR  in  ADDR_WIDTH  read address.
ARPROT  in  3  accepted and ignored.
ARVALID / ARREADY  in / out  1  read-address handshake.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response.
RVALID / RREADY  out / in  1  read-data handshake.
regs_out  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset (ARESET=1 at a rising edge):
  - AWREADY, WREADY, ARREADY, BVALID and RVALID are 0.
  - BRESP, RRESP and RDATA are 0.
  - Every register is set to RESET_VALUE.
  - Both FSMs go to IDLE and any in-flight transaction is dropped with no response.
  - In the first cycle after reset deasserts, AWREADY, WREADY and ARREADY are 1. All ready and valid outputs are registered.
- Address decode:
  - LSB = log2(DATA_WIDTH/8); index = (addr - BASE_ADDR) >> LSB. Low LSB address bits are ignored, so misaligned addresses act on the containing word.
  - In range means BASE_ADDR <= addr < BASE_ADDR + NUM_REGS*DATA_WIDTH/8.
  - Response codes: OKAY = 2'b00, SLVERR = 2'b10.
- Write FSM, states W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW and W handshake in the same cycle: go to W_RESP.
    - AW only: capture the address, go to W_WAIT_DATA.
    - W only: capture data and strobes, go to W_WAIT_ADDR.
  - W_WAIT_DATA: AWREADY=0, WREADY=1; the W handshake moves the FSM to W_RESP.
  - W_WAIT_ADDR: WREADY=0, AWREADY=1; the AW handshake moves the FSM to W_RESP.
  - Commit on the edge that enters W_RESP:
    - In range and not RO: each byte k with WSTRB[k]=1 is updated; other bytes hold. BRESP=OKAY.
    - Out of range or RO: no register changes; BRESP=SLVERR.
    - WSTRB=0 in range: nothing is written; BRESP=OKAY.
  - W_RESP: BVALID=1 the cycle after the final handshake, with AWREADY=0 and WREADY=0. BVALID and BRESP hold until BREADY=1, then the FSM returns to W_IDLE and the ready signals are 1 the next cycle.
  - Only one write is outstanding at a time.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1. On the AR handshake, RDATA and RRESP are registered and the FSM goes to R_RESP, with RVALID=1 the next cycle (latency 1).
  - Out-of-range read: RDATA=0, RRESP=SLVERR. Reads of RO registers are legal and return OKAY.
  - R_RESP: ARREADY=0. RVALID, RDATA and RRESP hold until RREADY=1, then the FSM returns to R_IDLE.
- Read/write collision: when the AR handshake and a write commit to the same register occur on the same edge, the read returns the pre-write value. The next read returns the new value.
- regs_out reflects register contents continuously and updates on the commit edge.
- Read and write channels never stall each other.

Test Plan:
1. Reset, then write 0xDEADBEEF to BASE+0x4 with WSTRB=4'hF, AW and W in the same cycle -> BVALID one cycle later with BRESP=00. Reading 0x4 returns RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after the AR handshake.
2. Register 2 holds 0x11223344; present W (0xAABBCCDD, WSTRB=4'b0101) three cycles before AW=0x8 -> WREADY=0 while waiting, BRESP=00, register 2 becomes 0x11BB33DD.
3. Write to BASE + NUM_REGS*4 (0x40), then read 0x40 -> BRESP=10 and no register changes; RDATA=0, RRESP=10.
4. RO_MASK bit 3 set; write 0x5 to 0xC -> BRESP=10, register 3 stays at RESET_VALUE, and a read of 0xC returns OKAY.
5. Hold BREADY and RREADY low for 5 cycles -> BVALID, BRESP, RVALID and RDATA stay stable and AWREADY/ARREADY stay 0. Same-edge write and read of register 1 (old value 0x0, new 0x7) -> read returns 0x0 and the following read returns 0x7.
6. Assert ARESET while in W_WAIT_DATA and R_RESP -> all registers equal RESET_VALUE, BVALID and RVALID are 0, and readies are 1 the cycle after reset deasserts. Repeat test 1 with DATA_WIDTH=64 and NUM_REGS=8 (stride 8, WSTRB 8 bits).
